// File: rtl/filter_pkg.sv
// Shared constants and commit-sequencer state encoding for the filter rule table.
// Both the commit controller and the parser import this package.
package filter_pkg;

    localparam int NUM_RULES  = 20;
    localparam int RULE_WIDTH = 128;
    localparam int RULE_IDX_W = 5;
    localparam int CNT_WIDTH  = 16;

    // IDLE  | waiting for a commit request
    // DRAIN | holding off new packets until the parser is quiescent
    // COPY  | writing one snapshot rule per cycle into the active table
    // DONE  | one-cycle completion pulse, then IDLE or a follow-up DRAIN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        COPY  = 2'd2,
        DONE  = 2'd3
    } commit_state_e;

endpackage

// File: rtl/pkt_boundary_tracker.sv
// Tracks whether the snooped AXI-Stream is mid-packet and whether the parser is idle.
// The parser instantiates this too, so both sides agree on where packet boundaries fall.
module pkt_boundary_tracker (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tvalid_i,
    input  logic tready_i,
    input  logic tlast_i,
    input  logic lookup_busy_i,
    output logic in_pkt_o,
    output logic quiescent_o
);

    logic in_pkt_q;
    logic in_pkt_d;
    logic beat;

    assign beat = tvalid_i & tready_i;

    always_comb begin
        in_pkt_d = in_pkt_q;
        if (beat) begin
            in_pkt_d = ~tlast_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_pkt_q <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
        end
    end

    // A handshake in the current cycle means the stream is still active.
    assign in_pkt_o    = in_pkt_q;
    assign quiescent_o = ~in_pkt_q & ~lookup_busy_i & ~beat;

endmodule

// File: rtl/rule_commit_ctrl.sv
// Atomic rule-table commit: snapshot the staged rules, drain the parser at a
// packet boundary, then copy the snapshot into the active table one rule per cycle.
module rule_commit_ctrl
    import filter_pkg::*;
(
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic                            commit_req,
    input  logic [NUM_RULES*RULE_WIDTH-1:0] staged_rules,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic                            lookup_busy,
    output logic                            hold,
    output logic                            tbl_wr_en,
    output logic [RULE_IDX_W-1:0]           tbl_wr_addr,
    output logic [RULE_WIDTH-1:0]           tbl_wr_data,
    output logic                            commit_busy,
    output logic                            commit_done,
    output logic [CNT_WIDTH-1:0]            commit_count
);

    localparam logic [RULE_IDX_W-1:0] LAST_IDX = RULE_IDX_W'(NUM_RULES - 1);

    commit_state_e         state_q, state_d;
    logic [RULE_IDX_W-1:0] idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [RULE_WIDTH-1:0] snap_q [NUM_RULES];
    logic                  snap_en;
    logic                  in_pkt;
    logic                  quiescent;

    pkt_boundary_tracker u_tracker (
        .clk_i         (axi_aclk),
        .rst_i         (axi_reset),
        .tvalid_i      (s_axis_tvalid),
        .tready_i      (s_axis_tready),
        .tlast_i       (s_axis_tlast),
        .lookup_busy_i (lookup_busy),
        .in_pkt_o      (in_pkt),
        .quiescent_o   (quiescent)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        count_d   = count_q;
        snap_en   = 1'b0;
        if (commit_req && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = DRAIN;
                    snap_en = 1'b1;
                end
            end
            DRAIN: begin
                if (quiescent && !in_pkt) begin
                    state_d = COPY;
                    idx_d   = '0;
                end
            end
            COPY: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    count_d = count_q + CNT_WIDTH'(1);
                end else begin
                    idx_d = idx_q + RULE_IDX_W'(1);
                end
            end
            DONE: begin
                // A request landing in the DONE cycle itself folds into the follow-up.
                if (pending_q || commit_req) begin
                    state_d   = DRAIN;
                    pending_d = 1'b0;
                    snap_en   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            count_q   <= '0;
            for (int i = 0; i < NUM_RULES; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            if (snap_en) begin
                for (int i = 0; i < NUM_RULES; i++) begin
                    snap_q[i] <= staged_rules[i*RULE_WIDTH +: RULE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        hold        = 1'b0;
        commit_busy = 1'b0;
        commit_done = 1'b0;
        tbl_wr_en   = 1'b0;
        tbl_wr_addr = '0;
        tbl_wr_data = snap_q[0];
        case (state_q)
            DRAIN: begin
                hold        = 1'b1;
                commit_busy = 1'b1;
            end
            COPY: begin
                hold        = 1'b1;
                commit_busy = 1'b1;
                tbl_wr_en   = 1'b1;
                tbl_wr_addr = idx_q;
                tbl_wr_data = snap_q[idx_q];
            end
            DONE: begin
                commit_busy = 1'b1;
                commit_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign commit_count = count_q;

endmodule

// File: tb/tb_rule_commit_ctrl.sv
// Scoreboard bench for rule_commit_ctrl: each commit pushes its expected table
// writes; a negedge monitor pops and compares whenever the DUT writes the table.
module tb_rule_commit_ctrl;
    import filter_pkg::*;

    logic                            axi_aclk = 1'b0;
    logic                            axi_reset;
    logic                            commit_req;
    logic [NUM_RULES*RULE_WIDTH-1:0] staged_rules;
    logic                            s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic                            lookup_busy;
    logic                            hold, tbl_wr_en, commit_busy, commit_done;
    logic [RULE_IDX_W-1:0]           tbl_wr_addr;
    logic [RULE_WIDTH-1:0]           tbl_wr_data;
    logic [CNT_WIDTH-1:0]            commit_count;

    rule_commit_ctrl dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .commit_req    (commit_req),
        .staged_rules  (staged_rules),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .lookup_busy   (lookup_busy),
        .hold          (hold),
        .tbl_wr_en     (tbl_wr_en),
        .tbl_wr_addr   (tbl_wr_addr),
        .tbl_wr_data   (tbl_wr_data),
        .commit_busy   (commit_busy),
        .commit_done   (commit_done),
        .commit_count  (commit_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct packed {
        logic [RULE_IDX_W-1:0] addr;
        logic [RULE_WIDTH-1:0] data;
    } wr_t;

    logic [RULE_WIDTH-1:0] stg [NUM_RULES];
    wr_t  exp_q [$];
    wr_t  mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_dones = 0;
    int   done_seen = 0;
    int   exp_count = 0;
    int   wr_since = 0;

    always_comb begin
        for (int i = 0; i < NUM_RULES; i++) begin
            staged_rules[i*RULE_WIDTH +: RULE_WIDTH] = stg[i];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic rand_stg();
        for (int i = 0; i < NUM_RULES; i++) begin
            stg[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Reference model: a commit copies the staged words, in index order, once.
    task automatic push_commit();
        for (int i = 0; i < NUM_RULES; i++) begin
            exp_q.push_back('{addr: RULE_IDX_W'(i), data: stg[i]});
        end
        exp_dones++;
        exp_count++;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (!commit_done && k < budget) begin
            step();
            k++;
        end
        n_vec++;
        if (!commit_done) begin
            n_err++;
            $display("FAIL %s: commit_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic rand_traffic();
        s_axis_tvalid = 1'($urandom_range(0, 1));
        s_axis_tready = 1'($urandom_range(0, 1));
        s_axis_tlast  = ($urandom_range(0, 2) == 0);
        lookup_busy   = ($urandom_range(0, 3) == 0);
    endtask

    always @(negedge axi_aclk) begin
        if (axi_reset) begin
            wr_since = 0;
        end else begin
            if (tbl_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %0d data %h, none expected", tbl_wr_addr, tbl_wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", tbl_wr_addr, mon_e.addr);
                    chk("wr_data", tbl_wr_data, mon_e.data);
                end
                chk("wr_hold", hold, 1);
                wr_since++;
            end else begin
                chk("idle_addr", tbl_wr_addr, 0);
            end
            if (commit_done) begin
                chk("done_writes", wr_since, NUM_RULES);
                chk("done_hold", hold, 0);
                wr_since = 0;
                done_seen++;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tail;
        int d0;
        logic [31:0] w;
        axi_reset = 1'b1;
        commit_req = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        s_axis_tlast = 1'b0;
        lookup_busy = 1'b0;
        for (int i = 0; i < NUM_RULES; i++) stg[i] = '1;
        step();
        step();
        chk("rst_hold", hold, 0);
        chk("rst_wr_en", tbl_wr_en, 0);
        chk("rst_addr", tbl_wr_addr, 0);
        chk("rst_data", tbl_wr_data, 0);
        chk("rst_busy", commit_busy, 0);
        chk("rst_done", commit_done, 0);
        chk("rst_count", commit_count, 0);
        axi_reset = 1'b0;
        step();

        // Idle commit with known pattern and exact cycle timing
        for (int i = 0; i < NUM_RULES; i++) begin
            w = 32'hA0 + 32'(i);
            stg[i] = {4{w}};
        end
        push_commit();
        pulse_commit();
        chk("t1_hold_rise", hold, 1);
        chk("t1_drain_no_wr", tbl_wr_en, 0);
        step();
        chk("t1_first_wr", tbl_wr_en, 1);
        chk("t1_first_addr", tbl_wr_addr, 0);
        for (int k = 1; k < NUM_RULES; k++) step();
        chk("t1_last_wr", tbl_wr_en, 1);
        chk("t1_last_addr", tbl_wr_addr, NUM_RULES - 1);
        step();
        chk("t1_done", commit_done, 1);
        chk("t1_done_hold", hold, 0);
        chk("t1_done_no_wr", tbl_wr_en, 0);
        step();
        chk("t1_done_once", commit_done, 0);
        chk("t1_idle_busy", commit_busy, 0);
        chk("t1_count", commit_count, exp_count);

        // Commit during a 4-beat packet, parser refuses new first beat while held
        rand_stg();
        s_axis_tvalid = 1'b1; s_axis_tready = 1'b1; s_axis_tlast = 1'b0;
        step();
        push_commit();
        pulse_commit();
        lookup_busy = 1'b1;
        chk("mid_hold_b3", hold, 1);
        chk("mid_no_wr_b3", tbl_wr_en, 0);
        step();
        s_axis_tlast = 1'b1;
        chk("mid_hold_b4", hold, 1);
        chk("mid_no_wr_b4", tbl_wr_en, 0);
        step();
        s_axis_tlast = 1'b0;
        tail = $urandom_range(1, 6);
        for (int k = 0; k < tail; k++) begin
            s_axis_tready = ~hold;
            chk("mid_refuse_hold", hold, 1);
            chk("mid_busy_no_wr", tbl_wr_en, 0);
            step();
        end
        lookup_busy = 1'b0;
        s_axis_tready = ~hold;
        chk("mid_quiet_hold", hold, 1);
        chk("mid_quiet_no_wr", tbl_wr_en, 0);
        step();
        chk("mid_copy_start", tbl_wr_en, 1);
        wait_done(NUM_RULES + 5, "mid_done");
        chk("mid_done_hold", hold, 0);
        s_axis_tready = 1'b1; s_axis_tlast = 1'b1;
        step();
        s_axis_tvalid = 1'b0; s_axis_tready = 1'b0; s_axis_tlast = 1'b0;
        chk("mid_count", commit_count, exp_count);

        // Follow-up commit requested during COPY; two requests collapse into one
        d0 = done_seen;
        rand_stg();
        push_commit();
        pulse_commit();
        step();
        for (int k = 0; k < 5; k++) step();
        chk("pend_idx5", tbl_wr_addr, 5);
        rand_stg();
        push_commit();
        pulse_commit();
        step(); step(); step();
        pulse_commit();
        wait_done(NUM_RULES + 5, "pend_done1");
        step();
        chk("pend_drain_hold", hold, 1);
        chk("pend_drain_busy", commit_busy, 1);
        chk("pend_drain_no_wr", tbl_wr_en, 0);
        step();
        chk("pend_copy2_start", tbl_wr_en, 1);
        step();
        wait_done(NUM_RULES + 5, "pend_done2");
        step();
        chk("pend_idle", commit_busy, 0);
        chk("pend_count", commit_count, exp_count);
        chk("pend_two_dones", done_seen - d0, 2);

        // Snapshot integrity: staging cleared mid-copy
        rand_stg();
        push_commit();
        pulse_commit();
        step();
        for (int i = 0; i < NUM_RULES; i++) stg[i] = '0;
        wait_done(NUM_RULES + 5, "snap_done");
        step();
        chk("snap_count", commit_count, exp_count);

        // lookup_busy held for 100 cycles keeps the controller draining
        rand_stg();
        push_commit();
        lookup_busy = 1'b1;
        pulse_commit();
        for (int k = 0; k < 100; k++) begin
            chk("lb_hold", hold, 1);
            chk("lb_no_wr", tbl_wr_en, 0);
            step();
        end
        lookup_busy = 1'b0;
        chk("lb_last_drain", tbl_wr_en, 0);
        step();
        chk("lb_copy_start", tbl_wr_en, 1);
        wait_done(NUM_RULES + 5, "lb_done");
        step();

        // Reset in the middle of COPY aborts the commit
        rand_stg();
        push_commit();
        pulse_commit();
        step();
        for (int k = 0; k < 7; k++) step();
        chk("rstc_idx7", tbl_wr_addr, 7);
        axi_reset = 1'b1;
        step();
        exp_q.delete();
        exp_dones--;
        exp_count = 0;
        chk("rstc_hold", hold, 0);
        chk("rstc_wr_en", tbl_wr_en, 0);
        chk("rstc_addr", tbl_wr_addr, 0);
        chk("rstc_data", tbl_wr_data, 0);
        chk("rstc_busy", commit_busy, 0);
        chk("rstc_count", commit_count, 0);
        axi_reset = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rand_stg();
        push_commit();
        pulse_commit();
        step();
        chk("rstc_restart_wr", tbl_wr_en, 1);
        chk("rstc_restart_addr", tbl_wr_addr, 0);
        wait_done(NUM_RULES + 5, "rstc_done");
        step();
        chk("rstc_count_after", commit_count, exp_count);

        // Randomized stream traffic and parser activity around commits
        for (int it = 0; it < 6; it++) begin
            rand_stg();
            push_commit();
            commit_req = 1'b1;
            rand_traffic();
            step();
            commit_req = 1'b0;
            for (int k = 0; k < 500 && !commit_done; k++) begin
                rand_traffic();
                step();
            end
            n_vec++;
            if (!commit_done) begin
                n_err++;
                $display("FAIL rand_done: iteration %0d commit_done not seen within 500 cycles", it);
            end
            s_axis_tvalid = 1'b0;
            lookup_busy = 1'b0;
            step();
            chk("rand_count", commit_count, exp_count);
        end

        step(); step();
        chk("queue_empty", exp_q.size(), 0);
        chk("done_total", done_seen, exp_dones);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
